// File: rtl/alu_issue_sched_if.sv
// ============================================================================
// Module  : alu_issue_sched_if
// Brief   : Bundle handshake between the op source and the ALU issue scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_issue_sched_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_en;
    logic [2:0]  in_wen;
    logic [5:0]  in_index;
    logic [17:0] in_rA;
    logic [17:0] in_rB;

    modport master (
        output in_valid, in_en, in_wen, in_index, in_rA, in_rB,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_en, in_wen, in_index, in_rA, in_rB,
        output in_ready
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue_sched.sv
// ============================================================================
// Module  : alu_issue_sched
// Brief   : Splits a 3-slot ALU bundle into dependency-free issue phases.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_sched #(
    parameter bit CHAIN01 = 1'b1,
    parameter int CNT_W   = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             stall_i,
    alu_issue_sched_if.slave      bus,
    output logic [2:0]            iss_en_o,
    output logic [1:0]            iss_phase_o,
    output logic                  do_stall_o,
    output logic [2:0]            do_split_o,
    output logic [CNT_W-1:0]      split_cnt_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ISS  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [1:0]       p_q, p_d;
    logic [1:0]       nph_q, nph_d;
    logic [5:0]       ph_q, ph_d;
    logic [2:0]       en_q, en_d;
    logic [2:0]       iss_en_q, iss_en_d;
    logic [1:0]       iss_phase_q, iss_phase_d;
    logic [2:0]       do_split_q, do_split_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Forwarding tag each slot's result is known by inside the bundle
    logic [5:0] w_tag [3];
    for (genvar g = 0; g < 3; g++) begin : g_tag
        assign w_tag[g] = {4'b1100, bus.in_index[2*g +: 2]};
    end

    function automatic logic src_hit(input logic [5:0] ra, input logic [5:0] rb,
                                     input logic [5:0] tag);
        return (ra == tag) || (rb == tag);
    endfunction

    function automatic logic [2:0] phase_mask(input logic [5:0] ph, input logic [2:0] en,
                                              input logic [1:0] k);
        logic [2:0] m;
        m = 3'b000;
        for (int s = 0; s < 3; s++) begin
            m[s] = en[s] && (ph[2*s +: 2] == k);
        end
        return m;
    endfunction

    logic       w_dep10, w_dep20, w_dep21;
    logic [1:0] w_ph1, w_ph2, w_ph2a, w_ph2b, w_maxph;
    logic [5:0] w_ph;
    logic [2:0] w_split;
    logic       w_last, w_accept;

    assign w_dep10 = bus.in_en[1] & bus.in_en[0] & bus.in_wen[0]
                   & src_hit(bus.in_rA[11:6], bus.in_rB[11:6], w_tag[0]);
    assign w_dep20 = bus.in_en[2] & bus.in_en[0] & bus.in_wen[0]
                   & src_hit(bus.in_rA[17:12], bus.in_rB[17:12], w_tag[0]);
    assign w_dep21 = bus.in_en[2] & bus.in_en[1] & bus.in_wen[1]
                   & src_hit(bus.in_rA[17:12], bus.in_rB[17:12], w_tag[1]);

    // Slot 1 may chain off slot 0 in-phase; slot 2 must always wait a phase
    assign w_ph1   = (w_dep10 && !CHAIN01) ? 2'd1 : 2'd0;
    assign w_ph2a  = w_dep20 ? 2'd1 : 2'd0;
    assign w_ph2b  = w_dep21 ? (w_ph1 + 2'd1) : 2'd0;
    assign w_ph2   = (w_ph2a > w_ph2b) ? w_ph2a : w_ph2b;
    assign w_maxph = (w_ph2 > w_ph1) ? w_ph2 : w_ph1;
    assign w_ph    = {w_ph2, w_ph1, 2'd0};
    assign w_split = {(w_ph2 != 2'd0), (w_ph1 != 2'd0), 1'b0};

    assign w_last        = (p_q == (nph_q - 2'd1));
    assign bus.in_ready  = !stall_i && ((state_q == ST_IDLE) || w_last);
    assign w_accept      = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            p_q         <= 2'd0;
            nph_q       <= 2'd1;
            ph_q        <= 6'd0;
            en_q        <= 3'd0;
            iss_en_q    <= 3'd0;
            iss_phase_q <= 2'd0;
            do_split_q  <= 3'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            nph_q       <= nph_d;
            ph_q        <= ph_d;
            en_q        <= en_d;
            iss_en_q    <= iss_en_d;
            iss_phase_q <= iss_phase_d;
            do_split_q  <= do_split_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        nph_d       = nph_q;
        ph_d        = ph_q;
        en_d        = en_q;
        iss_en_d    = iss_en_q;
        iss_phase_d = iss_phase_q;
        do_split_d  = do_split_q;
        cnt_d       = cnt_q;
        if (!stall_i) begin
            if ((state_q == ST_ISS) && !w_last) begin
                p_d         = p_q + 2'd1;
                iss_en_d    = phase_mask(ph_q, en_q, p_q + 2'd1);
                iss_phase_d = p_q + 2'd1;
            end else if (w_accept) begin
                state_d     = ST_ISS;
                p_d         = 2'd0;
                nph_d       = w_maxph + 2'd1;
                ph_d        = w_ph;
                en_d        = bus.in_en;
                iss_en_d    = phase_mask(w_ph, bus.in_en, 2'd0);
                iss_phase_d = 2'd0;
                do_split_d  = w_split;
                if ((w_split != 3'd0) && (cnt_q != C_CNT_MAX)) begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end else begin
                state_d     = ST_IDLE;
                p_d         = 2'd0;
                iss_en_d    = 3'd0;
                iss_phase_d = 2'd0;
                do_split_d  = 3'd0;
            end
        end
    end

    assign iss_en_o    = iss_en_q;
    assign iss_phase_o = iss_phase_q;
    assign do_stall_o  = (state_q == ST_ISS) && !w_last;
    assign do_split_o  = do_split_q;
    assign split_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_sched.sv
// ============================================================================
// Module  : tb_alu_issue_sched
// Brief   : Random bundles into two schedulers (CHAIN01=1/CNT_W=4, CHAIN01=0/CNT_W=16).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_sched;

    localparam int C_CYCLES = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic stall;

    alu_issue_sched_if bus_a ();
    alu_issue_sched_if bus_b ();

    logic [2:0]  iss_en_a, iss_en_b;
    logic [1:0]  iss_phase_a, iss_phase_b;
    logic        do_stall_a, do_stall_b;
    logic [2:0]  do_split_a, do_split_b;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    alu_issue_sched #(.CHAIN01(1'b1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .stall_i(stall), .bus(bus_a.slave),
        .iss_en_o(iss_en_a), .iss_phase_o(iss_phase_a), .do_stall_o(do_stall_a),
        .do_split_o(do_split_a), .split_cnt_o(cnt_a)
    );

    alu_issue_sched #(.CHAIN01(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .stall_i(stall), .bus(bus_b.slave),
        .iss_en_o(iss_en_b), .iss_phase_o(iss_phase_b), .do_stall_o(do_stall_b),
        .do_split_o(do_split_b), .split_cnt_o(cnt_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stimulus shared by both instances
    logic        v_valid;
    logic [2:0]  v_en, v_wen;
    logic [5:0]  v_idx;
    logic [17:0] v_ra, v_rb;

    // Reference model: per-instance list of issue masks for the held bundle
    bit         m_chain [2] = '{1'b1, 1'b0};
    int         m_max   [2] = '{15, 65535};
    bit         m_busy  [2];
    logic [2:0] m_en    [2];
    logic [2:0] m_split [2];
    int         m_cnt   [2];
    int         m_pidx  [2];
    int         m_nph   [2];
    logic [2:0] m_masks [2][3];

    function automatic logic [5:0] tag_of(input int i);
        return {4'b1100, v_idx[2*i +: 2]};
    endfunction

    function automatic bit dep(input int j, input int i);
        return v_en[j] && v_en[i] && v_wen[i] &&
               ((v_ra[6*j +: 6] == tag_of(i)) || (v_rb[6*j +: 6] == tag_of(i)));
    endfunction

    function automatic logic [5:0] rand_src();
        if ($urandom_range(0, 1) == 1) return {4'b1100, 2'($urandom)};
        return 6'($urandom);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0; m_en[d] = 3'd0; m_split[d] = 3'd0;
            m_cnt[d] = 0; m_pidx[d] = 0; m_nph[d] = 1;
        end
    endtask

    task automatic model_accept(input int d);
        int ph [3];
        int a, b, mx;
        ph[0] = 0;
        ph[1] = (dep(1, 0) && !m_chain[d]) ? 1 : 0;
        a = dep(2, 0) ? ph[0] + 1 : 0;
        b = dep(2, 1) ? ph[1] + 1 : 0;
        ph[2] = (a > b) ? a : b;
        mx = 0;
        m_split[d] = 3'd0;
        for (int k = 0; k < 3; k++) m_masks[d][k] = 3'd0;
        for (int s = 0; s < 3; s++) begin
            if (v_en[s]) begin
                if (ph[s] > mx) mx = ph[s];
                m_masks[d][ph[s]][s] = 1'b1;
                if (ph[s] > 0) m_split[d][s] = 1'b1;
            end
        end
        m_nph[d]  = mx + 1;
        m_pidx[d] = 0;
        m_en[d]   = m_masks[d][0];
        m_busy[d] = 1'b1;
        if (m_split[d] != 3'd0 && m_cnt[d] < m_max[d]) m_cnt[d]++;
    endtask

    task automatic model_step(input int d);
        if (rst) begin
            m_busy[d] = 1'b0; m_en[d] = 3'd0; m_split[d] = 3'd0;
            m_cnt[d] = 0; m_pidx[d] = 0; m_nph[d] = 1;
        end else if (!stall) begin
            if (m_busy[d] && (m_pidx[d] + 1 < m_nph[d])) begin
                m_pidx[d]++;
                m_en[d] = m_masks[d][m_pidx[d]];
            end else if (v_valid) begin
                model_accept(d);
            end else begin
                m_busy[d] = 1'b0; m_en[d] = 3'd0; m_split[d] = 3'd0; m_pidx[d] = 0;
            end
        end
    endtask

    task automatic drive();
        bus_a.in_valid = v_valid; bus_b.in_valid = v_valid;
        bus_a.in_en    = v_en;    bus_b.in_en    = v_en;
        bus_a.in_wen   = v_wen;   bus_b.in_wen   = v_wen;
        bus_a.in_index = v_idx;   bus_b.in_index = v_idx;
        bus_a.in_rA    = v_ra;    bus_b.in_rA    = v_ra;
        bus_a.in_rB    = v_rb;    bus_b.in_rB    = v_rb;
    endtask

    task automatic randomize_inputs();
        int mode;
        rst     = ($urandom_range(0, 199) == 0);
        stall   = ($urandom_range(0, 4) == 0);
        v_valid = ($urandom_range(0, 9) < 7);
        v_idx   = 6'($urandom);
        v_wen   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
        v_en    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
        v_ra    = {rand_src(), rand_src(), rand_src()};
        v_rb    = {rand_src(), rand_src(), rand_src()};
        mode    = $urandom_range(0, 9);
        if (mode == 0) begin
            // Chained bundle: slot1 reads slot0, slot2 reads slot1
            v_en = 3'b111; v_wen = 3'b111;
            v_ra = {6'h00, tag_of(0), 6'h01};
            v_rb = {tag_of(1), 6'h02, 6'h03};
        end else if (mode == 1) begin
            v_en = 3'b111; v_wen = 3'b110;
            v_ra = {tag_of(0), tag_of(0), 6'h05};
            v_rb = 18'd0;
        end else if (mode == 2) begin
            v_en = 3'b000;
        end
    endtask

    task automatic check_dut(input int d);
        logic [2:0]  g_en, g_split;
        logic [1:0]  g_ph;
        logic        g_stall, g_rdy;
        logic [31:0] g_cnt;
        bit          e_rdy, e_dstall;
        if (d == 0) begin
            g_en = iss_en_a; g_ph = iss_phase_a; g_stall = do_stall_a;
            g_split = do_split_a; g_cnt = 32'(cnt_a); g_rdy = bus_a.in_ready;
        end else begin
            g_en = iss_en_b; g_ph = iss_phase_b; g_stall = do_stall_b;
            g_split = do_split_b; g_cnt = 32'(cnt_b); g_rdy = bus_b.in_ready;
        end
        e_dstall = m_busy[d] && (m_pidx[d] + 1 < m_nph[d]);
        e_rdy    = !stall && (!m_busy[d] || (m_pidx[d] + 1 >= m_nph[d]));
        check_eq($sformatf("dut%0d.iss_en", d),    32'(g_en),    32'(m_en[d]));
        check_eq($sformatf("dut%0d.do_stall", d),  32'(g_stall), 32'(e_dstall));
        check_eq($sformatf("dut%0d.do_split", d),  32'(g_split), 32'(m_split[d]));
        check_eq($sformatf("dut%0d.split_cnt", d), g_cnt,        32'(m_cnt[d]));
        check_eq($sformatf("dut%0d.in_ready", d),  32'(g_rdy),   32'(e_rdy));
        if (m_busy[d]) check_eq($sformatf("dut%0d.iss_phase", d), 32'(g_ph), 32'(m_pidx[d]));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        v_valid = 1'b0; v_en = 3'd0; v_wen = 3'd0; v_idx = 6'd0; v_ra = 18'd0; v_rb = 18'd0;
        drive();
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_dut(0);
        check_dut(1);
        for (int cyc = 0; cyc < C_CYCLES; cyc++) begin
            @(negedge clk);
            randomize_inputs();
            drive();
            #1;
            check_dut(0);
            check_dut(1);
            @(posedge clk);
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        #1;
        check_dut(0);
        check_dut(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
